lsu: RTL and testbench

Load/store unit directly downstream of the ALU. It takes the ALU result as the effective address for RV32I loads and stores. It runs a single word-wide request/grant/response transaction on the data bus, with byte enables and lane replication for stores and sign or zero extension for loads. While a transaction is in flight it asserts `stall` so the core holds PC and the instruction.

---
 rtl/lsu.sv | 150 +++++++++++++++
 tb/tb_lsu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one word-wide req/gnt/rvalid bus transaction per RV32I
// load or store, with store lane replication, load extension and core stall.
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    output logic [31:0] ld_data,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    // state | meaning
    // IDLE  | no transaction; launches on a valid aligned access
    // REQ   | bus_req high, bus fields held until bus_gnt
    // WAIT  | load granted, waiting for bus_rvalid
    // DONE  | instruction retires; always returns to IDLE
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic        supported;
    logic        access;
    logic        mis_raw;
    logic        launch;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [2:0]  op_f3;
    logic [1:0]  op_off;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_off;
    logic [31:0] rd_word;
    logic [31:0] ext_data;

    // Access decode: legality, alignment and lane selection
    always_comb begin
        supported = 1'b0;
        mis_raw   = 1'b0;
        be_nxt    = 4'b0000;
        wdata_nxt = st_data;
        case (funct3)
            3'b000, 3'b100: begin
                supported = 1'b1;
                be_nxt    = 4'b0001 << addr[1:0];
                wdata_nxt = {4{st_data[7:0]}};
            end
            3'b001, 3'b101: begin
                supported = 1'b1;
                mis_raw   = addr[0];
                be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{st_data[15:0]}};
            end
            3'b010: begin
                supported = 1'b1;
                mis_raw   = (addr[1:0] != 2'b00);
                be_nxt    = 4'b1111;
                wdata_nxt = st_data;
            end
            default: begin
                supported = 1'b0;
            end
        endcase
        access     = (mem_rd | mem_wr) & supported;
        launch     = (state == IDLE) & access & ~mis_raw;
        misaligned = ~rst & (state == IDLE) & access & mis_raw;
        stall      = ~rst & (launch | (state == REQ) | (state == WAIT));
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (launch) state_nxt = REQ;
            REQ:  if (bus_gnt) state_nxt = bus_we ? DONE : WAIT;
            WAIT: if (bus_rvalid) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Bus fields captured at launch; bus_req drops on grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'h0;
            bus_wdata <= 32'h0;
            op_f3     <= 3'b000;
            op_off    <= 2'b00;
        end else if (launch) begin
            bus_req   <= 1'b1;
            bus_we    <= ~mem_rd;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_nxt;
            bus_wdata <= wdata_nxt;
            op_f3     <= funct3;
            op_off    <= addr[1:0];
        end else if (state == REQ && bus_gnt) begin
            bus_req   <= 1'b0;
        end
    end

    // Read word and its extraction controls update together on completion,
    // so ld_data holds steady until the next load finishes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_word <= 32'h0;
            ld_f3   <= 3'b000;
            ld_off  <= 2'b00;
        end else if (state == WAIT && bus_rvalid) begin
            rd_word <= bus_rdata;
            ld_f3   <= op_f3;
            ld_off  <= op_off;
        end
    end

    // Load extraction from the read register
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = rd_word[8*ld_off +: 8];
        half_sel = ld_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (ld_f3)
            3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext_data = {24'h0, byte_sel};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext_data = {16'h0, half_sel};
            default: ext_data = rd_word;
        endcase
        ld_data = misaligned ? 32'h0 : ext_data;
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a behavioural model.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] ld_data;
    logic        stall;
    logic        misaligned;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] prev_ld  = 32'h0;

    lsu dut (
        .clk(clk), .rst(rst), .addr(addr), .st_data(st_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
        .ld_data(ld_data), .stall(stall), .misaligned(misaligned),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // One instruction: drive it, act as memory, check every cycle
    task automatic txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rdat, input int gd, input int rvd);
        bit          sup, acc, mis, load;
        int          sz, stalls;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_ld;
        sup  = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        acc  = (rd || wr) && sup;
        sz   = (f3 == 2) ? 4 : ((f3 == 1 || f3 == 5) ? 2 : 1);
        mis  = acc && ((a % sz) != 0);
        load = rd;
        e_be = (sz == 4) ? 4'hF : ((sz == 2) ? ((a % 4 >= 2) ? 4'hC : 4'h3) : 4'(1 << (a % 4)));
        e_wd = (sz == 4) ? sd : ((sz == 2) ? (sd & 32'hFFFF) * 32'h00010001
                                           : (sd & 32'hFF) * 32'h01010101);
        e_ld = ref_load(f3, a[1:0], rdat);
        mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; st_data = sd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        if (!acc || mis) begin
            check("noacc_stall", 32'(stall), 0);
            check("misaligned", 32'(misaligned), 32'(mis));
            check("noacc_ld", ld_data, mis ? 32'h0 : prev_ld);
            tick;
            mem_rd = 1'b0; mem_wr = 1'b0;
            @(negedge clk);
            check("noacc_req", 32'(bus_req), 0);
            tick;
            return;
        end
        check("launch_stall", 32'(stall), 1);
        check("launch_mis", 32'(misaligned), 0);
        check("launch_req", 32'(bus_req), 0);
        stalls = 1;
        tick;
        for (int i = 0; i <= gd; i++) begin
            bus_gnt    = (i == gd);
            bus_rvalid = 1'($urandom);
            bus_rdata  = $urandom;
            @(negedge clk);
            check("req_req", 32'(bus_req), 1);
            check("req_we", 32'(bus_we), 32'(!load));
            check("req_addr", bus_addr, a & 32'hFFFFFFFC);
            check("req_be", 32'(bus_be), 32'(e_be));
            if (!load) check("req_wdata", bus_wdata, e_wd);
            stalls += int'(stall);
            tick;
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        if (load) begin
            for (int j = 0; j <= rvd; j++) begin
                bus_rvalid = (j == rvd);
                bus_rdata  = (j == rvd) ? rdat : $urandom;
                @(negedge clk);
                check("wait_req", 32'(bus_req), 0);
                stalls += int'(stall);
                tick;
            end
            bus_rvalid = 1'b0;
        end
        @(negedge clk);
        check("done_stall", 32'(stall), 0);
        check("done_req", 32'(bus_req), 0);
        check("done_ld", ld_data, load ? e_ld : prev_ld);
        check("stall_cycles", 32'(stalls), 32'(2 + gd + (load ? rvd + 1 : 0)));
        if (load) prev_ld = e_ld;
        tick;
        mem_rd = 1'b0; mem_wr = 1'b0;
        @(negedge clk);
        check("after_req", 32'(bus_req), 0);
        check("after_stall", 32'(stall), 0);
        check("after_ld", ld_data, prev_ld);
        tick;
    endtask

    initial begin
        logic [2:0] f3;
        bit         rd, wr;
        rst = 1'b1; addr = 32'h100; st_data = 0; mem_rd = 1'b1; mem_wr = 1'b0;
        funct3 = 3'b010; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 0);
        check("rst_req", 32'(bus_req), 0);
        check("rst_addr", bus_addr, 0);
        check("rst_be", 32'(bus_be), 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_ld", ld_data, 0);
        addr = 32'h102;
        #1;
        check("rst_mis", 32'(misaligned), 0);
        mem_rd = 1'b0;
        tick;
        rst = 1'b0;
        tick;

        txn(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0);
        txn(1, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 0, 0);
        check("lb_0x103", prev_ld, 32'hFFFFFF80);
        txn(1, 0, 3'b100, 32'h103, 0, 32'h80FF1234, 0, 0);
        check("lbu_0x103", prev_ld, 32'h00000080);
        txn(1, 0, 3'b001, 32'h102, 0, 32'h80FF1234, 0, 0);
        check("lh_0x102", prev_ld, 32'hFFFF80FF);
        txn(0, 1, 3'b000, 32'h201, 32'h000000AB, 0, 0, 0);
        txn(0, 1, 3'b001, 32'h202, 32'h1234CDEF, 0, 0, 0);
        txn(1, 0, 3'b010, 32'h102, 0, 0, 0, 0);
        txn(0, 1, 3'b001, 32'h301, 32'h55, 0, 0, 0);
        txn(1, 0, 3'b010, 32'h400, 0, 32'hCAFEF00D, 3, 1);
        txn(1, 1, 3'b101, 32'h502, 32'hFFFFFFFF, 32'h9876ABCD, 1, 0);
        txn(1, 0, 3'b011, 32'h600, 0, 0, 0, 0);

        // Reset while waiting for read data
        mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h40;
        tick;
        bus_gnt = 1'b1;
        tick;
        bus_gnt = 1'b0; mem_rd = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rstw_req", 32'(bus_req), 0);
        check("rstw_stall", 32'(stall), 0);
        check("rstw_ld", ld_data, 0);
        #1 rst = 1'b0;
        prev_ld = 32'h0;
        tick;
        txn(1, 0, 3'b010, 32'h44, 0, 32'h13579BDF, 0, 0);

        for (int n = 0; n < 200; n++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (wr && !rd) begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
                    3: f3 = 3'b011; 4: f3 = 3'b110; default: f3 = 3'b111;
                endcase
            end else begin
                f3 = 3'($urandom);
            end
            txn(rd, wr, f3, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
